usb_buffer_reader: RTL and testbench

USB_BUFFER_READER -- requirements
Module: usb_buffer_reader

---
 rtl/usb_buffer_pkg.sv | 16 +
 rtl/usb_buffer_rd_ptr.sv | 47 ++++
 rtl/usb_buffer_reader.sv | 133 +++++++++++++
 tb/tb_usb_buffer_reader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_buffer_pkg.sv
// Shared definitions for the USB buffer reader: default geometry and FSM state encoding.
package usb_buffer_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 64;
   localparam int DEF_ADDR_W = 6;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      PRESENT = 3'd2,
      DONE    = 3'd3,
      ERR     = 3'd4
   } rd_state_e;

endpackage

// File: rtl/usb_buffer_rd_ptr.sv
// Read pointer and remaining-byte counter for the buffer reader.
// The pointer survives between packets; only clear or rst returns it to zero.
module usb_buffer_rd_ptr
   import usb_buffer_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic [ADDR_W:0]   load_len,
   input  logic              advance,
   output logic [ADDR_W-1:0] rd_ptr,
   output logic              last
);

   logic [ADDR_W-1:0] ptr_r;
   logic [ADDR_W:0]   rem_r;

   // Pointer wrap and countdown; clear outranks load, load outranks advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r <= '0;
         rem_r <= '0;
      end else if (clear) begin
         ptr_r <= '0;
         rem_r <= '0;
      end else if (load) begin
         rem_r <= load_len;
      end else if (advance) begin
         if (ptr_r == ADDR_W'(DEPTH - 1)) begin
            ptr_r <= '0;
         end else begin
            ptr_r <= ptr_r + ADDR_W'(1'b1);
         end
         if (rem_r != '0) begin
            rem_r <= rem_r - (ADDR_W+1)'(1'b1);
         end
      end
   end

   assign rd_ptr = ptr_r;
   assign last   = (rem_r == (ADDR_W+1)'(1'b1));

endmodule

// File: rtl/usb_buffer_reader.sv
// Drains a packet from the USB buffer RAM into a valid/ready byte stream.
// First PRESENT cycle forwards the RAM output directly so a byte can leave every second cycle.
module usb_buffer_reader
   import usb_buffer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              start,
   input  logic [ADDR_W:0]   byte_len,
   input  logic [ADDR_W:0]   occupancy,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   input  logic [DATA_W-1:0] rd_data,
   output logic              pop,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done,
   output logic              underrun
);

   rd_state_e         state_r;
   rd_state_e         state_nxt_s;
   logic              load_s;
   logic              hs_s;
   logic              last_s;
   logic [ADDR_W-1:0] rd_ptr_s;
   logic              rd_en_r;
   logic              tx_valid_r;
   logic              busy_r;
   logic              done_r;
   logic              underrun_r;
   logic              fresh_r;
   logic [DATA_W-1:0] hold_r;

   assign hs_s = (state_r == PRESENT) && tx_ready && !clear;

   usb_buffer_rd_ptr #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_rd_ptr (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .load     (load_s),
      .load_len (byte_len),
      .advance  (hs_s),
      .rd_ptr   (rd_ptr_s),
      .last     (last_s)
   );

   // Next-state decode; start is only honoured from IDLE.
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      if (clear) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (!start) begin
                  state_nxt_s = IDLE;
               end else if (byte_len == '0) begin
                  state_nxt_s = DONE;
               end else if (byte_len > occupancy) begin
                  state_nxt_s = ERR;
               end else begin
                  state_nxt_s = FETCH;
                  load_s      = 1'b1;
               end
            end
            FETCH:   state_nxt_s = PRESENT;
            PRESENT: begin
               if (!tx_ready) begin
                  state_nxt_s = PRESENT;
               end else if (last_s) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = FETCH;
               end
            end
            DONE:    state_nxt_s = IDLE;
            ERR:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // State and output registers, loaded from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         rd_en_r    <= 1'b0;
         tx_valid_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         underrun_r <= 1'b0;
         fresh_r    <= 1'b0;
         hold_r     <= '0;
      end else begin
         state_r    <= state_nxt_s;
         rd_en_r    <= (state_nxt_s == FETCH);
         tx_valid_r <= (state_nxt_s == PRESENT);
         busy_r     <= (state_nxt_s == FETCH) || (state_nxt_s == PRESENT);
         done_r     <= (state_nxt_s == DONE);
         fresh_r    <= (state_nxt_s == PRESENT) && (state_r == FETCH);
         if (fresh_r) begin
            hold_r <= rd_data;
         end
         if (clear) begin
            underrun_r <= 1'b0;
         end else if (state_nxt_s == ERR) begin
            underrun_r <= 1'b1;
         end
      end
   end

   assign rd_addr  = rd_ptr_s;
   assign rd_en    = rd_en_r;
   assign pop      = hs_s;
   assign tx_data  = fresh_r ? rd_data : hold_r;
   assign tx_valid = tx_valid_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign underrun = underrun_r;

endmodule

// File: tb/tb_usb_buffer_reader.sv
// Scoreboard bench for usb_buffer_reader: a packet-level model queues expected bytes,
// addresses and done pulses; a negedge monitor compares what the DUT presents.
module tb_usb_buffer_reader;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;

   logic              clk = 1'b0;
   logic              rst, clear, start, tx_ready;
   logic [ADDR_W:0]   byte_len, occupancy;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_en, pop, tx_valid, busy, done, underrun;
   logic [DATA_W-1:0] rd_data, tx_data;

   logic [DATA_W-1:0] mem [DEPTH];
   int checks = 0, failures = 0, cyc = 0;
   int exp_q[$];
   int addr_q[$];
   int done_q[$];
   int m_ptr = 0;
   bit m_underrun = 1'b0;
   int ready_mode = 2;
   int prev_hs = -1, last_hs = -1;
   bit gap_chk = 1'b0;

   always #5 clk = ~clk;

   usb_buffer_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .clear(clear), .start(start),
      .byte_len(byte_len), .occupancy(occupancy),
      .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
      .pop(pop), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .done(done), .underrun(underrun)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: event seen, none required", name);
   endtask

   // Synchronous-read RAM behind the reader
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rd_en) rd_data <= mem[rd_addr];
   end

   // Ready generator: random or held high; mode 2 leaves tx_ready to the stimulus
   always @(posedge clk) begin
      #1;
      if (ready_mode == 0) tx_ready = 1'($urandom_range(0, 1));
      else if (ready_mode == 1) tx_ready = 1'b1;
   end

   // Monitor
   always @(negedge clk) begin
      int t;
      if (!rst) begin
         if (tx_valid && tx_ready && !clear) begin
            chk("pop_on_handshake", pop, 1);
            if (exp_q.size() == 0) fail("unexpected_byte");
            else chk("tx_data", tx_data, exp_q.pop_front());
            if (gap_chk && prev_hs >= 0) chk("handshake_gap", cyc - prev_hs, 2);
            prev_hs = cyc;
            last_hs = cyc;
         end else begin
            chk("pop_quiet", pop, 0);
         end
         if (rd_en) begin
            if (addr_q.size() == 0) fail("unexpected_rd_en");
            else chk("rd_addr", rd_addr, addr_q.pop_front());
         end
         if (done) begin
            if (done_q.size() == 0) fail("spurious_done");
            else begin
               t = done_q.pop_front();
               if (t != 0) chk("done_latency", cyc - last_hs, 1);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      exp_q.delete();
      addr_q.delete();
      done_q.delete();
   endtask

   task automatic issue(input int len, input int occ, input bit gap);
      byte_len  = (ADDR_W+1)'(len);
      occupancy = (ADDR_W+1)'(occ);
      start     = 1'b1;
      prev_hs   = -1;
      gap_chk   = gap;
      if (len == 0) done_q.push_back(0);
      else if (len > occ) m_underrun = 1'b1;
      else begin
         for (int i = 0; i < len; i++) begin
            addr_q.push_back((m_ptr + i) % DEPTH);
            exp_q.push_back(int'(mem[(m_ptr + i) % DEPTH]));
         end
         m_ptr = (m_ptr + len) % DEPTH;
         done_q.push_back(1);
      end
      tick();
      start = 1'b0;
      chk("underrun_after_start", underrun, m_underrun);
      if (len != 0 && len > occ) begin
         chk("err_no_rd_en", rd_en, 0);
         chk("err_not_busy", busy, 0);
         tick();
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0 || done_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL timeout: %0d bytes still pending, required 0", exp_q.size());
         flush();
      end
      chk("ptr_persist", rd_addr, m_ptr);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!tx_valid && n < 20) begin
         tick();
         n++;
      end
      if (!tx_valid) fail("tx_valid_timeout");
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      flush();
      m_ptr = 0;
      m_underrun = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_tx_data"}, tx_data, 0);
      chk({tag, "_tx_valid"}, tx_valid, 0);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_pop"}, pop, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_underrun"}, underrun, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int a0, len, occ;
      for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
      rst = 1'b1; clear = 1'b0; start = 1'b0; tx_ready = 1'b0;
      byte_len = '0; occupancy = '0;
      #12;
      check_all_zero("reset");
      tick();
      rst = 1'b0;
      tick();

      // Four bytes back to back with ready held high
      ready_mode = 1; tx_ready = 1'b1;
      issue(4, 4, 1'b1);
      wait_idle(100);

      // Walk the pointer to 62, then wrap across the top of the buffer
      issue(58, 64, 1'b1);
      wait_idle(400);
      issue(4, 4, 1'b0);
      wait_idle(100);

      // Zero-length packet completes immediately
      issue(0, 0, 1'b0);
      wait_idle(20);

      // Underrun is sticky across a following good packet until clear
      issue(5, 3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("underrun_sticky", underrun, 1);
      end
      issue(3, 3, 1'b0);
      wait_idle(100);
      chk("underrun_still_set", underrun, 1);
      do_clear();
      chk("clear_underrun", underrun, 0);
      chk("clear_ptr", rd_addr, 0);

      // Stall in PRESENT for 10 cycles; a stray start meanwhile is ignored
      ready_mode = 2; tx_ready = 1'b0;
      a0 = m_ptr;
      issue(2, 10, 1'b0);
      wait_valid();
      for (int i = 0; i < 10; i++) begin
         chk("stall_valid", tx_valid, 1);
         chk("stall_data", tx_data, mem[a0]);
         start = (i == 4); byte_len = 7'd1; occupancy = 7'd64;
         tick();
      end
      start = 1'b0;
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      ready_mode = 1;
      wait_idle(100);

      // Clear coinciding with the handshake of byte 2 of 6
      ready_mode = 2; tx_ready = 1'b0;
      issue(6, 6, 1'b0);
      wait_valid();
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      wait_valid();
      clear = 1'b1; tx_ready = 1'b1;
      tick();
      clear = 1'b0; tx_ready = 1'b0;
      flush(); m_ptr = 0; m_underrun = 1'b0;
      chk("clear_tx_valid", tx_valid, 0);
      chk("clear_busy", busy, 0);
      chk("clear_rd_addr", rd_addr, 0);
      for (int i = 0; i < 5; i++) tick();

      // Randomised packets, some oversized, occasional clears between them
      for (int k = 0; k < 25; k++) begin
         ready_mode = 0;
         len = $urandom_range(0, DEPTH);
         if ($urandom_range(0, 3) == 0) occ = $urandom_range(0, DEPTH);
         else occ = $urandom_range(len, DEPTH);
         issue(len, occ, 1'b0);
         wait_idle(2000);
         if ($urandom_range(0, 7) == 0) begin
            do_clear();
            chk("rand_clear_ptr", rd_addr, 0);
         end
      end

      // Reset in the middle of a full-buffer packet, then a clean full packet
      do_clear();
      ready_mode = 2; tx_ready = 1'b0;
      issue(64, 64, 1'b0);
      wait_valid();
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      flush(); m_ptr = 0; m_underrun = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_done", done, 0);
      ready_mode = 0;
      issue(64, 64, 1'b0);
      wait_idle(3000);
      for (int i = 0; i < 4; i++) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
